bin_to_bcd_serial: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one bit per clock.

---
 rtl/bin_to_bcd_serial.sv | 98 +++++++++
 tb/tb_bin_to_bcd_serial.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-BCD converter (shift-add-3), one input bit per clock.
// Accepts a word on start, returns packed BCD digits plus an overflow flag.
module bin_to_bcd_serial #(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e             state_q;
  logic [IN_W-1:0]    shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   adj_c;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               overflow_q;

  // One shift-add-3 step: correct digits >= 5, then shift the whole chain left.
  always_comb begin
    adj_c = scratch_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    scratch_d = {adj_c[BCD_W-2:0], shift_q[IN_W-1]};
    shift_d   = shift_q << 1;
    ovf_d     = ovf_q | adj_c[BCD_W-1];
    cnt_d     = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shift_q   <= bin_in;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= CNT_W'(IN_W);
            busy_q    <= 1'b1;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          shift_q   <= shift_d;
          scratch_q <= scratch_d;
          ovf_q     <= ovf_d;
          cnt_q     <= cnt_d;
          // Last input bit consumed on this edge: publish the result.
          if (cnt_q == CNT_W'(1)) begin
            bcd_q      <= scratch_d;
            overflow_q <= ovf_d;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Directed-vector bench for bin_to_bcd_serial: 3-digit instance plus a 2-digit
// instance for the overflow cases.
module tb_bin_to_bcd_serial;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic        overflow;

  logic        start2;
  logic [7:0]  bin2;
  logic        busy2;
  logic        done2;
  logic [7:0]  bcd2;
  logic        ovf2;

  int n_vec;
  int n_err;

  bin_to_bcd_serial #(.IN_W(8), .DIGITS(3)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  bin_to_bcd_serial #(.IN_W(8), .DIGITS(2)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .bin_in   (bin2),
    .busy     (busy2),
    .done     (done2),
    .bcd_out  (bcd2),
    .overflow (ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] dec3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Runs one conversion on the 3-digit instance; optionally pokes start/bin_in mid-run.
  task automatic run_conv(input logic [7:0] v, input int glitch_at,
                          output logic [11:0] bcd, output logic ovf,
                          output int lat, output int busy_n);
    logic [11:0] prev;
    int          changes;
    prev = bcd_out;
    changes = 0;
    @(negedge clk);
    start = 1'b1;
    bin_in = v;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      if (bcd_out !== prev) changes++;
      if (lat == glitch_at) begin
        start = 1'b1;
        bin_in = 8'd7;
      end else if (lat == glitch_at + 1) begin
        start = 1'b0;
        bin_in = 8'hC3;
      end
      @(negedge clk);
      lat++;
    end
    bcd = bcd_out;
    ovf = overflow;
    check("hold_during_shift", 32'(changes), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic run_conv2(input logic [7:0] v, output logic [7:0] bcd, output logic ovf);
    int lat;
    @(negedge clk);
    start2 = 1'b1;
    bin2 = v;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("d2_latency", 32'(lat), 32'd8);
    bcd = bcd2;
    ovf = ovf2;
  endtask

  initial begin
    logic [11:0] bcd;
    logic        ovf;
    logic [7:0]  b2;
    int          lat;
    int          busy_n;
    int          done_seen;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    bin_in = 8'd0;
    start2 = 1'b0;
    bin2 = 8'd0;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // Zero input
    run_conv(8'd0, -1, bcd, ovf, lat, busy_n);
    check("zero_bcd", 32'(bcd), 32'h000);
    check("zero_ovf", 32'(ovf), 32'd0);
    check("zero_latency", 32'(lat), 32'd8);

    // Full-scale input, busy width
    run_conv(8'd255, -1, bcd, ovf, lat, busy_n);
    check("max_bcd", 32'(bcd), 32'h255);
    check("max_ovf", 32'(ovf), 32'd0);
    check("max_latency", 32'(lat), 32'd8);
    check("max_busy_cycles", 32'(busy_n), 32'd8);

    // Back-to-back sweep, new start on each done cycle
    @(negedge clk);
    start = 1'b1;
    bin_in = 8'd0;
    for (int v = 0; v < 256; v++) begin
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("sweep_bcd", 32'(bcd_out), 32'(dec3(v)));
      check("sweep_latency", 32'(lat), 32'd8);
      if (v < 255) begin
        start = 1'b1;
        bin_in = 8'(v + 1);
      end
    end
    @(negedge clk);
    check("sweep_ovf", 32'(overflow), 32'd0);

    // Start and bin_in changes while busy are ignored
    run_conv(8'd99, 3, bcd, ovf, lat, busy_n);
    check("ignore_bcd", 32'(bcd), 32'h099);
    check("ignore_latency", 32'(lat), 32'd8);
    @(negedge clk);
    check("ignore_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-conversion
    @(negedge clk);
    start = 1'b1;
    bin_in = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd_out), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) rst_n = 1'b1;
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_conv(8'd42, -1, bcd, ovf, lat, busy_n);
    check("after_abort_bcd", 32'(bcd), 32'h042);

    // Two-digit instance: overflow boundary
    run_conv2(8'd100, b2, ovf);
    check("d2_100_ovf", 32'(ovf), 32'd1);
    run_conv2(8'd99, b2, ovf);
    check("d2_99_bcd", 32'(b2), 32'h99);
    check("d2_99_ovf", 32'(ovf), 32'd0);
    run_conv2(8'd255, b2, ovf);
    check("d2_255_ovf", 32'(ovf), 32'd1);
    run_conv2(8'd57, b2, ovf);
    check("d2_57_bcd", 32'(b2), 32'h57);
    check("d2_57_ovf", 32'(ovf), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
